cla_chain_ctrl: RTL and testbench



---
 rtl/cla_chain_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cla_chain_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_chain_ctrl.sv
// Nibble-serial sequencer around a 4-bit registered CLA: walks WIDTH-bit operands LSB nibble first.
// Optional two's-complement overflow output is enabled by defining CLA_CHAIN_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; adder drive holds last values
// EXEC  | nibble in flight; wcnt counts adder latency, then capture
// DONE  | one-cycle completion; start here is accepted back-to-back
module cla_chain_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_CHAIN_OVF_EN
  output logic             ovf,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(ADD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         add_a_q, add_a_d;
  logic [3:0]         add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   merged;
  logic [IDX_W-1:0]   nxt_idx;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    work_d    = work_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    ovf_d     = ovf_q;

    // Work value with the nibble currently leaving the adder merged in.
    merged = work_q;
    merged[4*int'(idx_q) +: 4] = add_s;
    nxt_idx = idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d       = op_a;
          b_d       = op_b;
          idx_d     = '0;
          wcnt_d    = '0;
          work_d    = '0;
          add_a_d   = op_a[3:0];
          add_b_d   = op_b[3:0];
          add_cin_d = cin;
          busy_d    = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (wcnt_q < LAT_C) begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end else begin
          work_d = merged;
          if (idx_q == LAST_IDX) begin
            sum_d   = merged;
            cout_d  = add_cout;
            ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d     = nxt_idx;
            wcnt_d    = '0;
            add_a_d   = a_q[4*int'(nxt_idx) +: 4];
            add_b_d   = b_q[4*int'(nxt_idx) +: 4];
            add_cin_d = add_cout;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      work_q    <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      work_q    <= work_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;

`ifdef CLA_CHAIN_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_chain_ctrl.sv
// Self-checking bench for cla_chain_ctrl: directed cases plus random operands against an arithmetic model.
// Two instances: ADD_LAT=1 (main) and ADD_LAT=2 (latency check).
module tb_cla_chain_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start1, cin1, busy1, done1, cout1, add_cin1, add_cout1, ovf1;
  logic [W-1:0]  opa1, opb1, sum1;
  logic [3:0]    add_a1, add_b1, add_s1;
  logic          start2, cin2, busy2, done2, cout2, add_cin2, add_cout2, ovf2;
  logic [W-1:0]  opa2, opb2, sum2;
  logic [3:0]    add_a2, add_b2, add_s2;

  cla_chain_ctrl #(.WIDTH(W), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(opa1), .op_b(opb1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
`ifdef CLA_CHAIN_OVF_EN
    .ovf(ovf1),
`endif
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1));

  cla_chain_ctrl #(.WIDTH(W), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(opa2), .op_b(opb2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
`ifdef CLA_CHAIN_OVF_EN
    .ovf(ovf2),
`endif
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2), .add_s(add_s2), .add_cout(add_cout2));

`ifndef CLA_CHAIN_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  // Registered 4-bit adders with 1 and 2 cycles of latency.
  logic [4:0] p1, p2a, p2b;
  always @(posedge clk) begin
    p1  <= {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};
    p2a <= {1'b0, add_a2} + {1'b0, add_b2} + {4'b0, add_cin2};
    p2b <= p2a;
  end
  assign {add_cout1, add_s1} = p1;
  assign {add_cout2, add_s2} = p2b;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Carry entering each nibble: bit 4k of the sum of the low 4k bits.
  function automatic logic [3:0] ref_carries(input logic [W-1:0] a, b, input logic c);
    logic [3:0] r;
    longint unsigned m, s;
    r[0] = c;
    for (int k = 1; k < 4; k++) begin
      m = (64'd1 << (4*k)) - 1;
      s = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
      r[k] = s[4*k];
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic c);
    logic [W:0] s;
    s = ref_sum(a, b, c);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (or timeout).
  task automatic run_op(input logic [W-1:0] a, b, input logic c, input int glitch_at, input string tag);
    int cnt;
    logic seen, busy_ok;
    logic [3:0] carries;
    logic [W:0] rs;
    opa1 = a; opb1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    opa1 = W'($urandom); opb1 = W'($urandom); cin1 = 1'($urandom);
    cnt = 0; seen = 1'b0; busy_ok = 1'b1; carries = '0;
    while (cnt < 40 && !seen) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (done1) seen = 1'b1;
      else begin
        if (busy1 !== 1'b1) busy_ok = 1'b0;
        if ((cnt % 2) == 1 && cnt < 8) carries[cnt/2] = add_cin1;
        if (cnt == glitch_at) begin
          start1 = 1'b1; opa1 = 16'h0F0F; opb1 = 16'h0101;
        end else start1 = 1'b0;
      end
    end
    start1 = 1'b0;
    rs = ref_sum(a, b, c);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cnt, 8);
    check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy1), 32'd0);
    check({tag, "_sum"}, 32'(sum1), 32'(rs[W-1:0]));
    check({tag, "_cout"}, 32'(cout1), 32'(rs[W]));
    check({tag, "_carries"}, 32'(carries), 32'(ref_carries(a, b, c)));
`ifdef CLA_CHAIN_OVF_EN
    check({tag, "_ovf"}, 32'(ovf1), 32'(ref_ovf(a, b, c)));
`endif
  endtask

  initial begin
    int extra, cnt;
    logic seen;
    logic [W-1:0] ra, rb;
    logic rc;
    rst = 1'b1; start1 = 0; start2 = 0;
    opa1 = '0; opb1 = '0; cin1 = 0; opa2 = '0; opb2 = '0; cin2 = 0;
    @(negedge clk);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_sum", 32'(sum1), 0);
    check("rst_cout", 32'(cout1), 0);
    check("rst_add", 32'({add_a1, add_b1, add_cin1}), 0);
    check("rst_ovf", 32'(ovf1), 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 0, "t1");
    check("t1_const_sum", 32'(sum1), 32'h5555);
    repeat (2) @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "t2");
    check("t2_const_sum", 32'(sum1), 32'h0000);
    repeat (3) @(negedge clk);
    check("t2_done_pulse_once", 32'(done1), 0);
    check("t2_sum_held", 32'(sum1), 32'h0000);
    check("t2_cout_held", 32'(cout1), 1);

    run_op(16'hABCD, 16'h1111, 1'b1, 0, "t3");
    check("t3_const_sum", 32'(sum1), 32'hBCDF);
    run_op(16'h8000, 16'h8000, 1'b0, 0, "t3b2b");
    check("t3b2b_const_cout", 32'(cout1), 1);

    repeat (2) @(negedge clk);
    run_op(16'h1234, 16'h4321, 1'b0, 3, "t4glitch");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || busy1) extra++;
    end
    check("t4_no_second_op", extra, 0);
    check("t4_sum_held", 32'(sum1), 32'h5555);

    // Abort mid-operation with reset.
    opa1 = 16'h2222; opb1 = 16'h3333; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy1), 0);
    check("abort_done", 32'(done1), 0);
    check("abort_sum", 32'(sum1), 0);
    check("abort_cout", 32'(cout1), 0);
    check("abort_add", 32'({add_a1, add_b1, add_cin1}), 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done1 || busy1) extra++;
    end
    check("abort_no_done", extra, 0);
    run_op(16'h0F0F, 16'h0101, 1'b0, 0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, rc, (i % 4 == 0) ? 5 : 0, $sformatf("rnd%0d", i));
    end

    // ADD_LAT=2 instance: 4 nibbles x 3 cycles.
    @(negedge clk);
    opa2 = 16'h7FFF; opb2 = 16'h0001; cin2 = 1'b0; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cnt = 0; seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    check("lat2_done_seen", 32'(seen), 1);
    check("lat2_latency", cnt, 12);
    check("lat2_sum", 32'(sum2), 32'h8000);
    check("lat2_cout", 32'(cout2), 0);
`ifdef CLA_CHAIN_OVF_EN
    check("lat2_ovf", 32'(ovf2), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
